// File: rtl/line_buffer_kxn.sv
// line_buffer_kxn: K-row vertical window generator over a run-time line width.
// One CH-channel column enters per in_valid; two cycles later the column is emitted
// together with the same column of the K-1 previous rows held in line memories.
// Optional feature macro: LB_ZERO_PAD_EN (top zero-padding from row 0).
module line_buffer_kxn #(
    parameter int DATA_W = 13,
    parameter int CH     = 9,
    parameter int K      = 3,
    parameter int MAX_W  = 1024,
    parameter int W_BITS = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [W_BITS-1:0]        cfg_width,
    input  logic                     in_valid,
    input  logic [CH*DATA_W-1:0]     in_data,
    output logic                     out_valid,
    output logic [K*CH*DATA_W-1:0]   out_data,
    output logic [W_BITS-1:0]        out_col,
    output logic                     out_last
);

    localparam int PW   = CH * DATA_W;
    localparam int AW   = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int RF_W = $clog2(K);
    localparam logic [W_BITS-1:0] MAXW_V = W_BITS'(MAX_W);
    localparam logic [RF_W-1:0]   RF_MAX = RF_W'(K - 1);

    logic [W_BITS-1:0] r_width;
    logic [W_BITS-1:0] r_col;
    logic [RF_W-1:0]   r_rf;

    logic [W_BITS-1:0] w_cfg_clamped;
    logic [W_BITS-1:0] w_width;
    logic [W_BITS-1:0] w_col;
    logic [RF_W-1:0]   w_rf;
    logic              w_last;
    logic              w_emit;

    logic              r_p1_acc;
    logic              r_p1_emit;
    logic [PW-1:0]     r_p1_data;
    logic [W_BITS-1:0] r_p1_col;
    logic              r_p1_last;
`ifdef LB_ZERO_PAD_EN
    logic [RF_W-1:0]   r_p1_rf;
`endif

    logic [(K-1)*PW-1:0] w_rd;
    logic [K*PW-1:0]     w_window;

    // Effective frame position: a start in this cycle makes the incoming sample column 0
    always_comb begin
        w_cfg_clamped = cfg_width;
        if (cfg_width < W_BITS'(2))
            w_cfg_clamped = W_BITS'(2);
        else if (cfg_width > MAXW_V)
            w_cfg_clamped = MAXW_V;
        w_width = start ? w_cfg_clamped : r_width;
        w_col   = start ? '0 : r_col;
        w_rf    = start ? '0 : r_rf;
        w_last  = (w_col == (w_width - W_BITS'(1)));
`ifdef LB_ZERO_PAD_EN
        w_emit  = in_valid;
`else
        w_emit  = in_valid && (w_rf == RF_MAX);
`endif
    end

    // Width latch, column counter and saturating count of completed rows
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_width <= MAXW_V;
            r_col   <= '0;
            r_rf    <= '0;
        end else begin
            if (start)
                r_width <= w_cfg_clamped;
            if (in_valid) begin
                if (w_last) begin
                    r_col <= '0;
                    r_rf  <= (w_rf == RF_MAX) ? w_rf : w_rf + RF_W'(1);
                end else begin
                    r_col <= w_col + W_BITS'(1);
                    r_rf  <= w_rf;
                end
            end else begin
                r_col <= w_col;
                r_rf  <= w_rf;
            end
        end
    end

    // Stage 1: hold the accepted column while the line memories return its taps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p1_acc  <= 1'b0;
            r_p1_emit <= 1'b0;
            r_p1_data <= '0;
            r_p1_col  <= '0;
            r_p1_last <= 1'b0;
`ifdef LB_ZERO_PAD_EN
            r_p1_rf   <= '0;
`endif
        end else begin
            r_p1_acc  <= in_valid;
            r_p1_emit <= w_emit;
            if (in_valid) begin
                r_p1_data <= in_data;
                r_p1_col  <= w_col;
                r_p1_last <= w_last;
`ifdef LB_ZERO_PAD_EN
                r_p1_rf   <= w_rf;
`endif
            end
        end
    end

    // Line memories form a shift chain: line j takes what line j-1 held for this column
    for (genvar j = 0; j < K - 1; j++) begin : g_line
        logic [PW-1:0] r_mem [MAX_W];
        logic [PW-1:0] r_rd;
        logic [PW-1:0] w_wr;

        if (j == 0) begin : g_first
            assign w_wr = r_p1_data;
        end else begin : g_chain
            assign w_wr = w_rd[(j-1)*PW +: PW];
        end

        assign w_rd[j*PW +: PW] = r_rd;

        // Synchronous read-before-write line memory
        always_ff @(posedge clk) begin
            if (in_valid)
                r_rd <= r_mem[w_col[AW-1:0]];
            if (r_p1_acc)
                r_mem[r_p1_col[AW-1:0]] <= w_wr;
        end
    end

    // Window assembly: tap 0 is the live column, tap t is line t-1
    always_comb begin
        w_window = '0;
        w_window[0 +: PW] = r_p1_data;
        for (int unsigned t = 1; t < K; t++) begin
`ifdef LB_ZERO_PAD_EN
            if (t <= int unsigned'(r_p1_rf))
                w_window[t*PW +: PW] = w_rd[(t-1)*PW +: PW];
`else
            w_window[t*PW +: PW] = w_rd[(t-1)*PW +: PW];
`endif
        end
    end

    // Output register: updates only on an emitted column, otherwise holds
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= r_p1_emit;
            if (r_p1_emit) begin
                out_data <= w_window;
                out_col  <= r_p1_col;
                out_last <= r_p1_last;
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_kxn.sv
// Scoreboard bench for line_buffer_kxn: a frame-array reference model predicts each
// window and its arrival cycle; a negedge monitor pops and compares.
module tb_line_buffer_kxn;

    localparam int DW   = 8;
    localparam int CH   = 2;
    localparam int K    = 3;
    localparam int MAXW = 16;
    localparam int WB   = 5;
    localparam int PW   = CH * DW;
    localparam int OW   = K * PW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [WB-1:0] cfg_width = '0;
    logic          in_valid = 1'b0;
    logic [PW-1:0] in_data = '0;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic [WB-1:0] out_col;
    logic          out_last;

    line_buffer_kxn #(.DATA_W(DW), .CH(CH), .K(K), .MAX_W(MAXW), .W_BITS(WB)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_width(cfg_width),
        .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid),
        .out_data(out_data), .out_col(out_col), .out_last(out_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [OW-1:0] data;
        logic [WB-1:0] col;
        logic          last;
        int            cyc;
    } exp_t;

    exp_t sbq[$];
    int n_vec = 0;
    int n_err = 0;
    logic [OW-1:0] last_data = '0;

    // Reference model: pixels of the current frame stored by (row, col)
    int m_width = MAXW;
    int m_col = 0;
    int m_row = 0;
    logic [PW-1:0] pix [int];

    function automatic int clamp_w(input int cw);
        if (cw < 2) return 2;
        if (cw > MAXW) return MAXW;
        return cw;
    endfunction

    task automatic model_step(input bit st, input int cw, input bit v, input logic [PW-1:0] d);
        exp_t e;
        bit emit;
        int r;
        if (st) begin
            m_width = clamp_w(cw);
            m_col = 0;
            m_row = 0;
            pix.delete();
        end
        if (v) begin
            pix[m_row * 64 + m_col] = d;
`ifdef LB_ZERO_PAD_EN
            emit = 1'b1;
`else
            emit = (m_row >= K - 1);
`endif
            if (emit) begin
                e.data = '0;
                for (int t = 0; t < K; t++) begin
                    r = m_row - t;
                    if (r >= 0 && pix.exists(r * 64 + m_col))
                        e.data[t*PW +: PW] = pix[r * 64 + m_col];
                end
                e.col  = WB'(m_col);
                e.last = (m_col == m_width - 1);
                e.cyc  = cyc + 2;
                sbq.push_back(e);
            end
            m_col++;
            if (m_col == m_width) begin
                m_col = 0;
                m_row++;
            end
        end
    endtask

    task automatic apply(input bit st, input int cw, input bit v, input logic [PW-1:0] d);
        @(posedge clk);
        #1;
        start     = st;
        cfg_width = WB'(cw);
        in_valid  = v;
        in_data   = d;
        model_step(st, cw, v, d);
    endtask

    // Channel 0 carries row*16+col so windows are easy to read; channel 1 is random
    task automatic send(input bit st, input int cw, input bit v);
        int r;
        int c;
        r = st ? 0 : m_row;
        c = st ? 0 : m_col;
        apply(st, cw, v, {8'($urandom), 8'(r * 16 + c)});
    endtask

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("reset_valid", OW'(out_valid), '0);
        check("reset_data", out_data, '0);
        sbq.delete();
        last_data = '0;
        m_width = MAXW;
        m_col = 0;
        m_row = 0;
        pix.delete();
        in_valid = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    // Monitor: compare every presented window against the scoreboard head
    always @(negedge clk) begin
        if (!reset) begin
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL missing_out: col %0d due at cycle %0d, out_valid stayed 0", sbq[0].col, sbq[0].cyc);
                void'(sbq.pop_front());
            end
            n_vec++;
            if (out_valid) begin
                if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
                    n_err++;
                    $display("FAIL unexpected_out: out_valid=1 col %0d at cycle %0d, required out_valid=0", out_col, cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if (out_data !== e.data || out_col !== e.col || out_last !== e.last) begin
                        n_err++;
                        $display("FAIL window: got data 0x%0h col %0d last %0b, required data 0x%0h col %0d last %0b",
                                 out_data, out_col, out_last, e.data, e.col, e.last);
                    end
                end
                last_data = out_data;
            end else if (out_data !== last_data) begin
                n_err++;
                $display("FAIL hold: out_data 0x%0h while idle, required 0x%0h", out_data, last_data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #3;
        check("rst_out_valid", OW'(out_valid), '0);
        check("rst_out_data", out_data, '0);
        check("rst_out_col", OW'(out_col), '0);
        check("rst_out_last", OW'(out_last), '0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Width 4, back-to-back, five rows
        send(1'b1, 4, 1'b1);
        repeat (19) send(1'b0, 0, 1'b1);

        // Same stream with random gaps
        send(1'b1, 4, 1'b1);
        while (m_row < 5) send(1'b0, 0, $urandom_range(0, 2) != 0);

        // Restart at row 3 col 1 with width 6
        send(1'b1, 4, 1'b1);
        while (!(m_row == 3 && m_col == 1)) send(1'b0, 0, 1'b1);
        send(1'b1, 6, 1'b1);
        while (m_row < 4) send(1'b0, 0, $urandom_range(0, 3) != 0);

        // Width clamping: 0 -> 2, MAX_W+5 -> MAX_W
        send(1'b1, 0, 1'b1);
        while (m_row < 5) send(1'b0, 0, 1'b1);
        send(1'b1, MAXW + 5, 1'b1);
        while (m_row < 4) send(1'b0, 0, $urandom_range(0, 4) != 0);

        // Reset mid-frame, then continue at the default width without a start
        mid_reset();
        while (m_row < 4) send(1'b0, 0, $urandom_range(0, 3) != 0);

        // Random mix of starts, widths and gaps
        repeat (600) send($urandom_range(0, 79) == 0, $urandom_range(0, 21), $urandom_range(0, 3) != 0);

        apply(1'b0, 0, 1'b0, '0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        #1;
        check("drain_empty", OW'(sbq.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
